// File: rtl/aclock_pkg.sv
// Shared types and helpers for the multi-alarm clock.
// Holds the alarm state enum, BCD load validation and binary-to-BCD split.
package aclock_pkg;

   localparam int MAX_HOUR = 23;
   localparam int MAX_MIN  = 59;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZED = 2'd2
   } alarm_state_t;

   // True when the four digits form a legal HH:MM
   function automatic logic bcd_valid_hm(
      input logic [1:0] h1,
      input logic [3:0] h0,
      input logic [3:0] m1,
      input logic [3:0] m0
   );
      int h;
      int m;
      h = int'(h1) * 10 + int'(h0);
      m = int'(m1) * 10 + int'(m0);
      return (h0 <= 4'd9) && (m1 <= 4'd9) && (m0 <= 4'd9) &&
             (h1 != 2'd3) && (h <= MAX_HOUR) && (m <= MAX_MIN);
   endfunction

   // {tens, ones} of a value 0..99
   function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/multi_alarm_clock_alarm_channel.sv
// One alarm channel: stored HH:MM, IDLE/RINGING/SNOOZED FSM, ring/snooze timers.
// In: clk_1s, reset, ld_i + h_i/m_i, current time, en_i, snooze_i, stop_i. Out: ringing_o, snoozed_o.
module alarm_channel
   import aclock_pkg::*;
#(
   parameter int SNOOZE_SEC = 300,
   parameter int RING_SEC   = 60
) (
   input  logic       clk_1s,
   input  logic       reset,
   input  logic       ld_i,
   input  logic [4:0] h_i,
   input  logic [5:0] m_i,
   input  logic [4:0] hour_i,
   input  logic [5:0] min_i,
   input  logic [5:0] sec_i,
   input  logic       en_i,
   input  logic       snooze_i,
   input  logic       stop_i,
   output logic       ringing_o,
   output logic       snoozed_o
);

   localparam logic [11:0] RING_LD = 12'(RING_SEC);
   localparam logic [11:0] SNZ_LD  = 12'(SNOOZE_SEC);

   alarm_state_t state_q, state_d;
   logic [4:0]   ah_q, ah_d;
   logic [5:0]   am_q, am_d;
   logic [11:0]  ring_q, ring_d;
   logic [11:0]  snz_q, snz_d;
   logic         match;

   assign match = en_i && (hour_i == ah_q) && (min_i == am_q) &&
                  (sec_i == 6'd0);

   always_ff @(posedge clk_1s or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ah_q    <= '0;
         am_q    <= '0;
         ring_q  <= '0;
         snz_q   <= '0;
      end else begin
         state_q <= state_d;
         ah_q    <= ah_d;
         am_q    <= am_d;
         ring_q  <= ring_d;
         snz_q   <= snz_d;
      end
   end

   // Timers hold N at entry; expiry fires on the edge that sees 1,
   // so a state lasts exactly N cycles.
   always_comb begin
      state_d = state_q;
      ah_d    = ah_q;
      am_d    = am_q;
      ring_d  = ring_q;
      snz_d   = snz_q;
      if (ld_i) begin
         ah_d = h_i;
         am_d = m_i;
      end
      if (!en_i || ld_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (match) begin
                  state_d = RINGING;
                  ring_d  = RING_LD;
               end
            end
            RINGING: begin
               if (stop_i) begin
                  state_d = IDLE;
               end else if (snooze_i) begin
                  state_d = SNOOZED;
                  snz_d   = SNZ_LD;
               end else if (ring_q <= 12'd1) begin
                  state_d = IDLE;
               end else begin
                  ring_d = ring_q - 12'd1;
               end
            end
            SNOOZED: begin
               if (stop_i) begin
                  state_d = IDLE;
               end else if (snz_q <= 12'd1) begin
                  state_d = RINGING;
                  ring_d  = RING_LD;
               end else begin
                  snz_d = snz_q - 12'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign ringing_o = (state_q == RINGING);
   assign snoozed_o = (state_q == SNOOZED);

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD clock with NUM_ALARMS alarms, snooze and ring timeout.
// In: clk_1s, reset, ld_time/ld_alarm/alarm_sel, BCD digits, al_en, snooze, stop_al. Out: BCD time, alarm, alarm_id, snoozed.
module multi_alarm_clock
   import aclock_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int SNOOZE_SEC = 300,
   parameter int RING_SEC   = 60,
   parameter int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk_1s,
   input  logic                  reset,
   input  logic                  ld_time,
   input  logic                  ld_alarm,
   input  logic [AW-1:0]         alarm_sel,
   input  logic [1:0]            h_in1,
   input  logic [3:0]            h_in0,
   input  logic [3:0]            m_in1,
   input  logic [3:0]            m_in0,
   input  logic [NUM_ALARMS-1:0] al_en,
   input  logic                  snooze,
   input  logic                  stop_al,
   output logic [1:0]            h_out1,
   output logic [3:0]            h_out0,
   output logic [3:0]            m_out1,
   output logic [3:0]            m_out0,
   output logic [3:0]            s_out1,
   output logic [3:0]            s_out0,
   output logic                  alarm,
   output logic [AW-1:0]         alarm_id,
   output logic [NUM_ALARMS-1:0] snoozed
);

   logic [4:0] hour_q, hour_d;
   logic [5:0] min_q, min_d;
   logic [5:0] sec_q, sec_d;
   logic       in_ok;
   logic [4:0] ld_h;
   logic [5:0] ld_m;
   logic [7:0] hb, mb, sb;
   logic [NUM_ALARMS-1:0] ring;

   // Wrapping of invalid digits is harmless: only used when in_ok
   assign in_ok = bcd_valid_hm(h_in1, h_in0, m_in1, m_in0);
   assign ld_h  = {3'b0, h_in1} * 5'd10 + {1'b0, h_in0};
   assign ld_m  = {2'b0, m_in1} * 6'd10 + {2'b0, m_in0};

   always_ff @(posedge clk_1s or posedge reset) begin
      if (reset) begin
         hour_q <= '0;
         min_q  <= '0;
         sec_q  <= '0;
      end else begin
         hour_q <= hour_d;
         min_q  <= min_d;
         sec_q  <= sec_d;
      end
   end

   always_comb begin
      hour_d = hour_q;
      min_d  = min_q;
      sec_d  = sec_q + 6'd1;
      if (ld_time && in_ok) begin
         hour_d = ld_h;
         min_d  = ld_m;
         sec_d  = '0;
      end else if (sec_q == 6'(MAX_MIN)) begin
         sec_d = '0;
         if (min_q == 6'(MAX_MIN)) begin
            min_d  = '0;
            hour_d = (hour_q == 5'(MAX_HOUR)) ? 5'd0 : hour_q + 5'd1;
         end else begin
            min_d = min_q + 6'd1;
         end
      end
   end

   assign hb     = bin_to_bcd2({2'b0, hour_q});
   assign mb     = bin_to_bcd2({1'b0, min_q});
   assign sb     = bin_to_bcd2({1'b0, sec_q});
   assign h_out1 = 2'(hb[7:4]);
   assign h_out0 = hb[3:0];
   assign m_out1 = mb[7:4];
   assign m_out0 = mb[3:0];
   assign s_out1 = sb[7:4];
   assign s_out0 = sb[3:0];

   for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
      alarm_channel #(
         .SNOOZE_SEC(SNOOZE_SEC),
         .RING_SEC  (RING_SEC)
      ) u_ch (
         .clk_1s   (clk_1s),
         .reset    (reset),
         .ld_i     (ld_alarm && in_ok && (alarm_sel == AW'(i))),
         .h_i      (ld_h),
         .m_i      (ld_m),
         .hour_i   (hour_q),
         .min_i    (min_q),
         .sec_i    (sec_q),
         .en_i     (al_en[i]),
         .snooze_i (snooze),
         .stop_i   (stop_al),
         .ringing_o(ring[i]),
         .snoozed_o(snoozed[i])
      );
   end

   assign alarm = |ring;

   always_comb begin
      alarm_id = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (ring[i]) alarm_id = AW'(i);
      end
   end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock.
// Directed scenarios plus random traffic against a seconds/deadline model.
module tb_multi_alarm_clock;

   localparam int NA  = 4;
   localparam int SNZ = 300;
   localparam int RNG = 60;

   logic       clk_1s = 1'b0;
   logic       reset;
   logic       ld_time, ld_alarm;
   logic [1:0] alarm_sel;
   logic [1:0] h_in1;
   logic [3:0] h_in0, m_in1, m_in0;
   logic [3:0] al_en;
   logic       snooze, stop_al;
   logic [1:0] h_out1;
   logic [3:0] h_out0, m_out1, m_out0, s_out1, s_out0;
   logic       alarm;
   logic [1:0] alarm_id;
   logic [3:0] snoozed;

   int checks   = 0;
   int failures = 0;

   // model: time as seconds of day, states 0 idle 1 ring 2 snooze
   int m_t;
   int m_n;
   int m_st[NA];
   int m_amin[NA];
   int m_rend[NA];
   int m_wake[NA];

   always #5 clk_1s = ~clk_1s;

   multi_alarm_clock #(
      .NUM_ALARMS(NA),
      .SNOOZE_SEC(SNZ),
      .RING_SEC  (RNG)
   ) dut (
      .clk_1s   (clk_1s),
      .reset    (reset),
      .ld_time  (ld_time),
      .ld_alarm (ld_alarm),
      .alarm_sel(alarm_sel),
      .h_in1    (h_in1),
      .h_in0    (h_in0),
      .m_in1    (m_in1),
      .m_in0    (m_in0),
      .al_en    (al_en),
      .snooze   (snooze),
      .stop_al  (stop_al),
      .h_out1   (h_out1),
      .h_out0   (h_out0),
      .m_out1   (m_out1),
      .m_out0   (m_out0),
      .s_out1   (s_out1),
      .s_out0   (s_out0),
      .alarm    (alarm),
      .alarm_id (alarm_id),
      .snoozed  (snoozed)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t = 0;
      for (int i = 0; i < NA; i++) begin
         m_st[i]   = 0;
         m_amin[i] = 0;
      end
   endtask

   task automatic model_edge();
      int  hv, mv;
      bit  tv, mt, ld;
      hv = int'(h_in1) * 10 + int'(h_in0);
      mv = int'(m_in1) * 10 + int'(m_in0);
      tv = (h_in0 <= 9) && (m_in1 <= 9) && (m_in0 <= 9) &&
           (h_in1 != 3) && (hv <= 23) && (mv <= 59);
      m_n++;
      for (int i = 0; i < NA; i++) begin
         mt = al_en[i] && (m_t == m_amin[i] * 60);
         ld = ld_alarm && tv && (int'(alarm_sel) == i);
         if (ld) m_amin[i] = hv * 60 + mv;
         if (!al_en[i] || ld) m_st[i] = 0;
         else if (m_st[i] == 1) begin
            if (stop_al) m_st[i] = 0;
            else if (snooze) begin
               m_st[i] = 2;
               m_wake[i] = m_n + SNZ;
            end else if (m_n >= m_rend[i]) m_st[i] = 0;
         end else if (m_st[i] == 2) begin
            if (stop_al) m_st[i] = 0;
            else if (m_n >= m_wake[i]) begin
               m_st[i] = 1;
               m_rend[i] = m_n + RNG;
            end
         end else if (mt) begin
            m_st[i] = 1;
            m_rend[i] = m_n + RNG;
         end
      end
      if (ld_time && tv) m_t = hv * 3600 + mv * 60;
      else m_t = (m_t + 1) % 86400;
   endtask

   task automatic check_all();
      int hh, mm, ss, id;
      logic [3:0] sz;
      bit any;
      hh = m_t / 3600;
      mm = (m_t / 60) % 60;
      ss = m_t % 60;
      id = 0;
      any = 0;
      sz = '0;
      for (int i = NA - 1; i >= 0; i--) begin
         if (m_st[i] == 1) begin
            id = i;
            any = 1;
         end
         sz[i] = (m_st[i] == 2);
      end
      chk("h1", h_out1, hh / 10);
      chk("h0", h_out0, hh % 10);
      chk("m1", m_out1, mm / 10);
      chk("m0", m_out0, mm % 10);
      chk("s1", s_out1, ss / 10);
      chk("s0", s_out0, ss % 10);
      chk("alarm", alarm, any);
      chk("alarm_id", alarm_id, id);
      chk("snoozed", snoozed, sz);
   endtask

   task automatic step();
      @(posedge clk_1s);
      model_edge();
      @(negedge clk_1s);
      check_all();
      ld_time  = 0;
      ld_alarm = 0;
      snooze   = 0;
      stop_al  = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_digits(input int h, input int m);
      h_in1 = 2'(h / 10);
      h_in0 = 4'(h % 10);
      m_in1 = 4'(m / 10);
      m_in0 = 4'(m % 10);
   endtask

   task automatic load_time(input int h, input int m);
      set_digits(h, m);
      ld_time = 1;
      step();
   endtask

   task automatic load_alarm(input int ch, input int h, input int m);
      set_digits(h, m);
      alarm_sel = 2'(ch);
      ld_alarm = 1;
      step();
   endtask

   task automatic async_reset();
      reset = 1;
      #1;
      model_reset();
      check_all();
      chk("rst_alarm", alarm, 0);
      @(posedge clk_1s);
      @(negedge clk_1s);
      reset = 0;
   endtask

   initial begin
      int th, tm;
      reset = 1;
      ld_time = 0; ld_alarm = 0; alarm_sel = 0;
      h_in1 = 0; h_in0 = 0; m_in1 = 0; m_in0 = 0;
      al_en = 0; snooze = 0; stop_al = 0;
      m_n = 0;
      model_reset();
      #1;
      check_all();
      @(negedge clk_1s);
      reset = 0;

      // rollover and invalid load
      load_time(23, 59);
      run(60);
      chk("rollover", {h_out1, h_out0, m_out1, m_out0, s_out1, s_out0}, 0);
      set_digits(24, 0);
      ld_time = 1;
      step();
      chk("bad_ld_s0", s_out0, 1);
      chk("bad_ld_h0", h_out0, 0);

      // single alarm: rise, timeout
      load_alarm(2, 7, 30);
      al_en = 4'b0100;
      load_time(7, 29);
      run(60);
      chk("pre_ring", alarm, 0);
      step();
      chk("ring_rise", alarm, 1);
      chk("ring_id", alarm_id, 2);
      chk("ring_sec", s_out0, 1);
      run(RNG - 1);
      chk("ring_hold", alarm, 1);
      step();
      chk("ring_tmo", alarm, 0);

      // snooze then stop
      load_time(7, 29);
      run(61);
      chk("ring2", alarm, 1);
      snooze = 1;
      step();
      chk("snz_off", alarm, 0);
      chk("snz_flag", snoozed, 4'b0100);
      run(SNZ - 1);
      chk("snz_wait", alarm, 0);
      step();
      chk("snz_wake", alarm, 1);
      stop_al = 1;
      step();
      chk("stop_al", alarm, 0);
      chk("stop_snz", snoozed, 0);

      // two channels, priority
      load_alarm(1, 6, 0);
      load_alarm(3, 6, 0);
      al_en = 4'b1010;
      load_time(5, 59);
      run(61);
      chk("dual_id", alarm_id, 1);
      al_en = 4'b1000;
      step();
      chk("dual_id3", alarm_id, 3);
      snooze = 1;
      stop_al = 1;
      step();
      chk("snz_stop", alarm, 0);
      chk("snz_stop_f", snoozed, 0);
      load_time(5, 59);
      run(61);
      chk("rering", alarm, 1);
      chk("rering_id", alarm_id, 3);
      stop_al = 1;
      step();

      // async reset while snoozed
      al_en = 4'b0100;
      load_time(7, 29);
      run(61);
      snooze = 1;
      step();
      run(100);
      chk("pre_rst_snz", snoozed, 4'b0100);
      al_en = 0;
      async_reset();
      run(SNZ + 10);

      // random traffic
      for (int r = 0; r < 10; r++) begin
         th = $urandom_range(0, 23);
         tm = $urandom_range(0, 57);
         al_en = 4'($urandom_range(0, 15));
         for (int c = 0; c < NA; c++) begin
            if ($urandom_range(0, 2) != 0)
               load_alarm(c, th, tm + $urandom_range(1, 2));
         end
         load_time(th, tm);
         for (int k = 0; k < 450; k++) begin
            snooze  = ($urandom_range(0, 39) == 0);
            stop_al = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 99) == 0) begin
               h_in1 = 2'($urandom_range(0, 3));
               h_in0 = 4'($urandom_range(0, 15));
               m_in1 = 4'($urandom_range(0, 15));
               m_in0 = 4'($urandom_range(0, 15));
               ld_time = 1;
            end
            if ($urandom_range(0, 99) == 0) begin
               set_digits(th, tm + $urandom_range(1, 2));
               alarm_sel = 2'($urandom_range(0, 3));
               ld_alarm = 1;
            end
            if ($urandom_range(0, 149) == 0)
               al_en = 4'($urandom_range(0, 15));
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised 24-hour time-of-day counter with `NUM_ALARMS` independently programmable alarms, snooze and automatic ring timeout. It runs on the 1 Hz tick clock `clk_1s`, is loaded from the front-panel BCD digit inputs, and drives the six-digit BCD display plus the alarm buzzer line.

## Interface

**Parameters**
- `NUM_ALARMS`, default 4: number of alarm channels, 1–16.
- `SNOOZE_SEC`, default 300: snooze duration in seconds, 1–4095.
- `RING_SEC`, default 60: auto-stop ring duration in seconds, 1–4095.
- `AW`, default `$clog2(NUM_ALARMS)` with a minimum of 1: alarm index width.

**Ports**
- `clk_1s` in, 1: 1 Hz tick clock. Every rising edge is one second.
- `reset` in, 1: asynchronous, active-high.
- `ld_time` in, 1: load the clock from `h_in*`/`m_in*`.
- `ld_alarm` in, 1: load alarm `alarm_sel` from `h_in*`/`m_in*`.
- `alarm_sel` in, `AW`: alarm channel addressed by `ld_alarm`.
- `h_in1` in, 2; `h_in0` in, 4; `m_in1` in, 4; `m_in0` in, 4: BCD digits of the value to load.
- `al_en` in, `NUM_ALARMS`: per-channel alarm enable (level).
- `snooze` in, 1: snooze every ringing channel.
- `stop_al` in, 1: silence every ringing or snoozed channel.
- `h_out1` out, 2; `h_out0`, `m_out1`, `m_out0`, `s_out1`, `s_out0` out, 4 each: current time as BCD.
- `alarm` out, 1: buzzer. High while any channel is RINGING.
- `alarm_id` out, `AW`: lowest-index RINGING channel. Valid only when `alarm` is high; 0 otherwise.
- `snoozed` out, `NUM_ALARMS`: per-channel SNOOZED flag.

## Operation

**Time counter**
- Held in binary registers: hour 0–23, minute 0–59, second 0–59.
- Each edge advances the time by one second. Rollover is 23:59:59 → 00:00:00.
- BCD outputs are decoded combinationally from the registers.
- `ld_time` sets hour:minute from the inputs and seconds to 0, replacing that edge's increment.
- An invalid load is ignored entirely: any BCD digit above 9, `h_in1`=3, hour above 23, or minute above 59. The clock keeps counting.
- `reset` clears the time to 00:00:00. Time is never loaded from the inputs during reset.

**Alarm channel i** (stored hour/minute, 3-state FSM)
- States are IDLE, RINGING and SNOOZED.
- `ld_alarm` with `alarm_sel`=i and a valid input stores hour:minute and forces the channel to IDLE. An invalid value or `alarm_sel` ≥ `NUM_ALARMS` is ignored.
- Match condition: current registers equal stored HH:MM:00 and `al_en[i]`=1.
- IDLE → RINGING on an edge where the match condition holds. The ring counter loads `RING_SEC`.
- RINGING → IDLE when `stop_al`=1, or when the ring counter reaches 0. The counter decrements once per edge.
- RINGING → SNOOZED when `snooze`=1 and `stop_al`=0. The snooze counter loads `SNOOZE_SEC`.
- SNOOZED → RINGING when the snooze counter reaches 0. The counter decrements once per edge, and the ring counter reloads on entry to RINGING.
- SNOOZED → IDLE on `stop_al`=1.
- Any state → IDLE on the next edge when `al_en[i]`=0.
- Priority within a channel, highest first: `al_en` low > `ld_alarm` to this channel > `stop_al` > `snooze` > counter expiry > match.
- A match while the channel is RINGING or SNOOZED is ignored.
- `ld_time` does not change any channel state. A match is evaluated on the pre-load time registers.
- Reset value of each channel: stored time 00:00, IDLE, both counters 0.

## Timing

- `alarm`, `alarm_id` and `snoozed` are registered-state decodes, all 0 in reset.
- Time outputs are 00:00:00 in reset.
- Match latency: the display shows HH:MM:00 during cycle k. `alarm` rises at the edge ending cycle k, together with the display stepping to HH:MM:01.
- `stop_al` or `snooze` sampled at edge k produces `alarm`=0 after edge k.
- Snooze → re-ring: `alarm` returns exactly `SNOOZE_SEC` edges after the snooze edge.
- Ring timeout: with no stop or snooze, `alarm` stays high for exactly `RING_SEC` cycles.
- Asserting `reset` mid-ring or mid-snooze clears `alarm` immediately and asynchronously.
- Several channels matching on the same edge all enter RINGING. `alarm_id` reports the lowest index.

## Structure

- Package `aclock_pkg` contains:
  - `alarm_state_t` enum (IDLE, RINGING, SNOOZED);
  - `bcd_valid_hm` validation function;
  - `bin_to_bcd2` split function;
  - constants `MAX_HOUR=23` and `MAX_MIN=59`.
- Sub-module `alarm_channel`: one FSM, stored time and counters. It is instantiated `NUM_ALARMS` times in a generate loop.
- The top level holds the time counter, load decode, BCD decode, and lowest-index priority encoder.

## Test plan

- Reset, then `ld_time` 23:59, then 60 edges → display 00:00:00. Also load 24:00 → ignored, counting continues.
- Alarm 2 = 07:30, `al_en`=4'b0100, `ld_time` 07:29 → `alarm` rises on the edge producing 07:30:01, `alarm_id`=2; with no input it falls after 60 cycles.
- Ringing, `snooze` one cycle → `alarm`=0, `snoozed[2]`=1; `alarm`=1 again after 300 edges; then `stop_al` → `alarm`=0, `snoozed`=0.
- Alarms 1 and 3 both 06:00 and enabled → both RINGING, `alarm_id`=1. Clear `al_en[1]` → `alarm_id`=3 next edge.
- `snooze` and `stop_al` asserted on the same edge while ringing → IDLE, `snoozed`=0. A later match at the next day's 06:00:00 rings again.
- Assert `reset` asynchronously while SNOOZED → all outputs 0 immediately. No ring after 300 edges unless re-armed.
